// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control slice: FSM states, opcodes,
// funct codes and the datapath select encodings.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOP and FUNCT to the ALU operation code and reports whether FUNCT
// names a supported R-type operation.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_legal
);

    logic [2:0] funct_ctrl;

    always_comb begin
        funct_legal = 1'b1;
        funct_ctrl  = ALU_ADD;
        case (funct)
            FN_ADD:  funct_ctrl = ALU_ADD;
            FN_SUB:  funct_ctrl = ALU_SUB;
            FN_AND:  funct_ctrl = ALU_AND;
            FN_OR:   funct_ctrl = ALU_OR;
            FN_SLT:  funct_ctrl = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (aluop)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_ctrl;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences the shared datapath, stalls on memory,
// counts retired instructions and keeps a sticky illegal-instruction flag.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       OP,
    input  logic [5:0]       FUNCT,
    input  logic             ZERO,
    input  logic             MEM_READY,
    output logic             IORD,
    output logic             MEMWRITE,
    output logic             IRWRITE,
    output logic             REGDST,
    output logic             MEM2REG,
    output logic             REGWRITE,
    output logic             ALUSRCA,
    output logic [1:0]       ALUSRCB,
    output logic [2:0]       ALU_CONTROL,
    output logic [1:0]       PCSRC,
    output logic             PCEN,
    output logic             ILLEGAL,
    output logic [CNT_W-1:0] RETIRED
);

    state_t     state, next;
    logic [1:0] aluop;
    logic       alu_on;
    logic [2:0] dec_ctrl;
    logic       funct_legal;
    logic       set_illegal, retire;

    // ALU op depends only on state, kept apart from the main decode to avoid a comb loop
    always_comb begin
        aluop  = ALUOP_ADD;
        alu_on = 1'b0;
        case (state)
            S_FETCH, S_DECODE, S_MEMADR, S_ADDIEX: alu_on = 1'b1;
            S_EXECUTE: begin alu_on = 1'b1; aluop = ALUOP_FUNCT; end
            S_BRANCH:  begin alu_on = 1'b1; aluop = ALUOP_SUB;   end
            default: ;
        endcase
    end

    alu_decoder u_alu_dec (
        .aluop       (aluop),
        .funct       (FUNCT),
        .alu_control (dec_ctrl),
        .funct_legal (funct_legal)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_FETCH;
            ILLEGAL <= 1'b0;
            RETIRED <= '0;
        end else begin
            state <= next;
            if (set_illegal) ILLEGAL <= 1'b1;
            if (retire)      RETIRED <= RETIRED + CNT_W'(1);
        end
    end

    always_comb begin
        next        = state;
        IORD        = 1'b0;
        MEMWRITE    = 1'b0;
        IRWRITE     = 1'b0;
        REGDST      = 1'b0;
        MEM2REG     = 1'b0;
        REGWRITE    = 1'b0;
        ALUSRCA     = 1'b0;
        ALUSRCB     = SRCB_REG;
        ALU_CONTROL = 3'b000;
        PCSRC       = PC_ALU;
        PCEN        = 1'b0;
        set_illegal = 1'b0;
        retire      = 1'b0;
        // Reset cycle: everything quiet so an aborted instruction writes nothing
        if (!RST) begin
            if (alu_on) ALU_CONTROL = dec_ctrl;
            case (state)
                S_FETCH: begin
                    ALUSRCB = SRCB_FOUR;
                    IRWRITE = MEM_READY;
                    PCEN    = MEM_READY;
                    if (MEM_READY) next = S_DECODE;
                end
                S_DECODE: begin
                    ALUSRCB = SRCB_IMM_SH;
                    case (OP)
                        OP_LW, OP_SW: next = S_MEMADR;
                        OP_RTYPE:     next = S_EXECUTE;
                        OP_BEQ:       next = S_BRANCH;
                        OP_ADDI:      next = S_ADDIEX;
                        OP_J:         next = S_JUMP;
                        default: begin next = S_FETCH; set_illegal = 1'b1; end
                    endcase
                end
                S_MEMADR: begin
                    ALUSRCA = 1'b1;
                    ALUSRCB = SRCB_IMM;
                    next    = (OP == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    IORD = 1'b1;
                    if (MEM_READY) next = S_MEMWB;
                end
                S_MEMWB: begin
                    MEM2REG  = 1'b1;
                    REGWRITE = 1'b1;
                    retire   = 1'b1;
                    next     = S_FETCH;
                end
                S_MEMWRITE: begin
                    IORD     = 1'b1;
                    MEMWRITE = MEM_READY;
                    retire   = MEM_READY;
                    if (MEM_READY) next = S_FETCH;
                end
                S_EXECUTE: begin
                    ALUSRCA = 1'b1;
                    next    = S_ALUWB;
                end
                S_ALUWB: begin
                    REGDST      = 1'b1;
                    REGWRITE    = funct_legal;
                    retire      = funct_legal;
                    set_illegal = !funct_legal;
                    next        = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSRCA = 1'b1;
                    PCSRC   = PC_ALUOUT;
                    PCEN    = ZERO;
                    retire  = 1'b1;
                    next    = S_FETCH;
                end
                S_ADDIEX: begin
                    ALUSRCA = 1'b1;
                    ALUSRCB = SRCB_IMM;
                    next    = S_ADDIWB;
                end
                S_ADDIWB: begin
                    REGWRITE = 1'b1;
                    retire   = 1'b1;
                    next     = S_FETCH;
                end
                S_JUMP: begin
                    PCSRC  = PC_JUMP;
                    PCEN   = 1'b1;
                    retire = 1'b1;
                    next   = S_FETCH;
                end
                default: next = S_FETCH;
            endcase
        end
    end

endmodule
